ps2_kbd_tx: RTL and testbench
=============================

Name: ps2_kbd_tx

Overview:
- PS/2 device-side transmitter: the keyboard end of the link whose host end is the ps2_keyboard receiver.
- Accepts scan-code bytes over a valid/ready interface and buffers them in a small FIFO.
- Serialises each byte onto ps2_clk/ps2_data as a standard 11-bit PS/2 frame.
- Used for on-chip loopback and self-test of the keyboard path, and as a stimulus source in simulation.

Parameters:
- CLK_HALF, 8: clk cycles per ps2_clk half-period (high phase and low phase each); must be >= 2.
- GAP, 16: idle clk cycles (ps2_clk=1, ps2_data=1) inserted after every frame's stop bit; must be >= 1.
- DEPTH, 8: FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- tx_data  input  8  scan-code byte to send
- tx_valid  input  1  tx_data is valid this cycle
- tx_ready  output  1  FIFO can accept a byte (count < DEPTH); combinational from the registered count
- ps2_clk  output  1  PS/2 clock, registered
- ps2_data  output  1  PS/2 data, registered
- busy  output  1  a frame or gap is in progress, or FIFO non-empty
- fifo_count  output  $clog2(DEPTH)+1  bytes currently buffered

Behaviour:
- Reset (rst=1 at a clk edge): next cycle ps2_clk=1, ps2_data=1, busy=0, fifo_count=0, tx_ready=1.
  - FIFO pointers cleared; FSM goes to IDLE.
  - A frame in flight is abandoned immediately; no completion of the current bit.
- Push: tx_valid && tx_ready at an edge writes tx_data.
  - tx_valid while full is ignored; the byte is dropped and the sender must hold it.
- Pop: occurs only in IDLE when fifo_count>0.
- Same-cycle push and pop: fifo_count unchanged, both take effect.
- FIFO is first-in first-out; pointers wrap modulo DEPTH.
- Frame bit order: start(0), d0..d7 (LSB first), parity, stop(1).
  - Parity is odd: parity = ~^data, so the number of 1s in data plus parity is odd.
- FSM states:
  - IDLE: ps2_clk=1, ps2_data=1. If FIFO non-empty: pop, load the 11-bit frame into the shift register, bit index=0, go to BIT_HI.
  - BIT_HI: ps2_data = current frame bit, set on entry; ps2_clk=1 for CLK_HALF cycles, then go to BIT_LO.
  - BIT_LO: ps2_clk=0 for CLK_HALF cycles; ps2_data held. Then, if bit index=10, go to GAP; else increment the index and go to BIT_HI.
  - GAP: ps2_clk=1, ps2_data=1 for GAP cycles, then go to IDLE.
- Data changes only while ps2_clk is high; it is stable across every falling edge, which is the receiver's sampling point.
- Latency: byte pushed at edge t into an empty FIFO with the FSM in IDLE:
  - pop at edge t+1;
  - ps2_data=0 (start bit) visible after edge t+2;
  - first ps2_clk fall after edge t+2+CLK_HALF.
- Frame length: 22*CLK_HALF cycles from start-bit data change to the end of the stop bit's low phase. Back-to-back frame period is 22*CLK_HALF+GAP+1 cycles (the +1 is the IDLE pop cycle).
- busy=0 only when in IDLE with fifo_count=0.

Optional Feature:
- Macro: PS2_KBD_TX_ERRINJ_EN.
- When defined:
  - Extra input err_inject (1 bit) is captured with each pushed byte; the FIFO is 9 bits wide.
  - A frame whose byte was pushed with err_inject=1 transmits inverted parity (even parity).
- When undefined: the port is absent, the FIFO is 8 bits wide, and parity is always odd.

Test Plan:
- Reset idle: hold rst 3 cycles, release, run 100 cycles -> ps2_clk=1, ps2_data=1, busy=0, fifo_count=0, tx_ready=1 throughout.
- Single byte: push 0x1C with CLK_HALF=8 -> ps2_data falls 2 cycles after the push. Values sampled at the 11 ps2_clk falling edges must be 0,0,0,1,1,1,0,0,0,0,1 (parity 0). The loopback ps2_keyboard must capture 0x1C.
- Parity extremes: push 0x00 then 0xFF ->
  - 0x00 parity bit = 1;
  - 0xFF parity bit = 1;
  - second frame's start bit begins exactly 22*8+16+1=193 cycles after the first frame's start bit.
- FIFO full/backpressure: hold tx_valid with DEPTH+3 distinct bytes while transmitting -> tx_ready drops when fifo_count=8. No byte is lost or duplicated, and bytes emerge in push order; a simultaneous push and pop leaves the count unchanged.
- Reset mid-frame: push 0xA5, assert rst during bit 4's low phase -> after the next edge ps2_clk=1, ps2_data=1, fifo_count=0. No further falling edges occur until a new push.
- Error injection (PS2_KBD_TX_ERRINJ_EN defined): push 0x1C with err_inject=1 -> parity bit sampled as 1, and the receiver flags or discards the frame; next byte 0x1C with err_inject=0 -> parity 0, received normally.

Source files
------------

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: FIFO-buffered scan-code bytes serialised as 11-bit odd-parity frames.
// Optional PS2_KBD_TX_ERRINJ_EN adds err_inject, which forces even parity on the tagged byte.
`timescale 1ns/1ps
module ps2_kbd_tx #(
  parameter int unsigned CLK_HALF = 8,
  parameter int unsigned GAP      = 16,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
`ifdef PS2_KBD_TX_ERRINJ_EN
  input  logic                     err_inject,
`endif
  output logic                     tx_ready,
  output logic                     ps2_clk,
  output logic                     ps2_data,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CW      = PTR_W + 1;
  localparam int unsigned CNT_MAX = (CLK_HALF > GAP) ? CLK_HALF : GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
`ifdef PS2_KBD_TX_ERRINJ_EN
  localparam int unsigned FIFO_W  = 9;
`else
  localparam int unsigned FIFO_W  = 8;
`endif

  typedef enum logic [1:0] {S_IDLE, S_BIT_HI, S_BIT_LO, S_GAP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          bit_q, bit_d;
  logic [10:0]         frame_q, frame_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ps2_clk_q, ps2_clk_d, ps2_data_q, ps2_data_d, busy_q, busy_d;
  logic [FIFO_W-1:0]   mem [DEPTH];
  logic [FIFO_W-1:0]   wr_word, rd_word;
  logic                push, pop, half_done, gap_done, parity;

  assign tx_ready   = (count_q < CW'(DEPTH));
  assign push       = tx_valid && tx_ready;
  assign pop        = (state_q == S_IDLE) && (count_q != '0);
  assign half_done  = (cnt_q == CNT_W'(CLK_HALF - 1));
  assign gap_done   = (cnt_q == CNT_W'(GAP - 1));
  assign rd_word    = mem[rd_ptr_q];

`ifdef PS2_KBD_TX_ERRINJ_EN
  assign wr_word    = {err_inject, tx_data};
  assign parity     = (~^rd_word[7:0]) ^ rd_word[8];
`else
  assign wr_word    = tx_data;
  assign parity     = ~^rd_word[7:0];
`endif

  // FIFO storage; contents need no reset since pointers and count gate every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_word;
  end

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      frame_q    <= '1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      frame_q    <= frame_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (count_q != '0) state_d = S_BIT_HI;
      S_BIT_HI: if (half_done) state_d = S_BIT_LO;
      S_BIT_LO: if (half_done) state_d = (bit_q == 4'd10) ? S_GAP : S_BIT_HI;
      S_GAP:    if (gap_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Phase counter, bit index, frame load and FIFO bookkeeping
  always_comb begin
    cnt_d    = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
    bit_d    = bit_q;
    frame_d  = frame_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (pop) begin
      bit_d   = '0;
      frame_d = {1'b1, parity, rd_word[7:0], 1'b0};
    end else if (state_q == S_BIT_LO && half_done && bit_q != 4'd10) begin
      bit_d   = bit_q + 4'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Output logic; line values follow the state by one registered cycle
  always_comb begin
    ps2_clk_d  = 1'b1;
    ps2_data_d = 1'b1;
    busy_d     = (state_d != S_IDLE) || (count_d != '0);
    if (state_q == S_BIT_LO) ps2_clk_d = 1'b0;
    if (state_q == S_BIT_HI || state_q == S_BIT_LO) ps2_data_d = frame_q[bit_q];
  end

  assign ps2_clk    = ps2_clk_q;
  assign ps2_data   = ps2_data_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: a line monitor decodes frames and compares them with
// frames computed from byte value, odd-parity rule and the frame/latency timing formulas.
`timescale 1ns/1ps
module tb_ps2_kbd_tx;
  localparam int unsigned CLK_HALF = 8;
  localparam int unsigned GAP      = 16;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned PERIOD   = 22 * CLK_HALF + GAP + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
`ifdef PS2_KBD_TX_ERRINJ_EN
  logic       err_inject = 1'b0;
`endif
  logic       tx_ready, ps2_clk, ps2_data, busy;
  logic [3:0] fifo_count;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;

  ps2_kbd_tx #(.CLK_HALF(CLK_HALF), .GAP(GAP), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
`ifdef PS2_KBD_TX_ERRINJ_EN
    .err_inject(err_inject),
`endif
    .tx_ready(tx_ready), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver-side monitor: only this block writes the capture queues
  logic [10:0]  rx_q[$];
  int unsigned  rx_t_q[$];
  int unsigned  rx_f_q[$];
  int           rx_rd = 0;
  int unsigned  fall_cnt = 0;
  int           stab_err = 0;
  logic         prev_clk = 1'b1, prev_data = 1'b1;
  bit           in_frame = 1'b0;
  int           nbit = 0;
  logic [10:0]  shv = '0;
  int unsigned  t_start = 0, t_fall = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      nbit = 0;
    end else begin
      if (!in_frame && prev_data && !ps2_data && ps2_clk) begin
        in_frame = 1'b1; nbit = 0; t_start = cyc;
      end
      if (prev_clk && !ps2_clk) begin
        fall_cnt++;
        if (in_frame) begin
          if (nbit == 0) t_fall = cyc;
          shv[nbit] = ps2_data;
          nbit++;
          if (nbit == 11) begin
            rx_q.push_back(shv); rx_t_q.push_back(t_start); rx_f_q.push_back(t_fall);
            in_frame = 1'b0; nbit = 0;
          end
        end
      end
      if (!prev_clk && !ps2_clk && prev_data !== ps2_data) stab_err++;
    end
    prev_clk = ps2_clk;
    prev_data = ps2_data;
  end

  // Expected frame: start 0, data LSB first, odd parity (optionally inverted), stop 1
  function automatic logic [10:0] exp_frame(input logic [7:0] b, input bit inj);
    int   ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    par = (ones % 2 == 0) ? 1'b1 : 1'b0;
    if (inj) par = ~par;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic push(input logic [7:0] b, output int unsigned t);
    @(negedge clk);
    for (int k = 0; k < 5000 && !tx_ready; k++) @(negedge clk);
    tx_data = b; tx_valid = 1'b1;
    @(posedge clk); #1;
    t = cyc; tx_valid = 1'b0;
  endtask

`ifdef PS2_KBD_TX_ERRINJ_EN
  task automatic push_err(input logic [7:0] b, input logic inj);
    @(negedge clk);
    for (int k = 0; k < 5000 && !tx_ready; k++) @(negedge clk);
    tx_data = b; tx_valid = 1'b1; err_inject = inj;
    @(posedge clk); #1;
    tx_valid = 1'b0; err_inject = 1'b0;
  endtask
`endif

  task automatic wait_idle();
    for (int k = 0; k < 5000 && busy; k++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++; if (ps2_clk !== 1'b1) begin errors++; $display("FAIL reset_clk cyc=%0d got=%b exp=1", i, ps2_clk); end
      checks++; if (ps2_data !== 1'b1) begin errors++; $display("FAIL reset_data cyc=%0d got=%b exp=1", i, ps2_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", i, busy); end
      checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count cyc=%0d got=%0d exp=0", i, fifo_count); end
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready cyc=%0d got=%b exp=1", i, tx_ready); end
    end
  endtask

  task automatic test_single();
    int unsigned t;
    logic [10:0] f, lit;
    lit = 11'b1_0_0001_1100_0;
    push(8'h1C, t);
    for (int k = 0; k < 600 && rx_q.size() < rx_rd + 1; k++) @(negedge clk);
    checks++;
    if (rx_q.size() < rx_rd + 1) begin
      errors++; $display("FAIL single_timeout got=%0d frames exp=%0d", rx_q.size() - rx_rd, 1);
    end else begin
      f = rx_q[rx_rd];
      checks++; if (f !== exp_frame(8'h1C, 1'b0)) begin errors++; $display("FAIL single_frame got=%b exp=%b", f, exp_frame(8'h1C, 1'b0)); end
      checks++; if (f !== lit) begin errors++; $display("FAIL single_bits got=%b exp=%b", f, lit); end
      checks++; if (f[8:1] !== 8'h1C) begin errors++; $display("FAIL single_loopback got=%h exp=1c", f[8:1]); end
      checks++; if (rx_t_q[rx_rd] - t != 2) begin errors++; $display("FAIL single_start_lat got=%0d exp=2", rx_t_q[rx_rd] - t); end
      checks++; if (rx_f_q[rx_rd] - t != 2 + CLK_HALF) begin errors++; $display("FAIL single_fall_lat got=%0d exp=%0d", rx_f_q[rx_rd] - t, 2 + CLK_HALF); end
      rx_rd++;
    end
    wait_idle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_parity();
    int unsigned t0, t1;
    logic [10:0] f0, f1;
    push(8'h00, t0);
    push(8'hFF, t1);
    // second push coincides with the first pop: count stays at one
    checks++; if (fifo_count !== 4'(2 - ((t1 >= t0 + 1) ? 1 : 0))) begin errors++; $display("FAIL parity_pushpop_count got=%0d exp=1", fifo_count); end
    for (int k = 0; k < 900 && rx_q.size() < rx_rd + 2; k++) @(negedge clk);
    checks++;
    if (rx_q.size() < rx_rd + 2) begin
      errors++; $display("FAIL parity_timeout got=%0d frames exp=2", rx_q.size() - rx_rd);
    end else begin
      f0 = rx_q[rx_rd]; f1 = rx_q[rx_rd + 1];
      checks++; if (f0 !== exp_frame(8'h00, 1'b0)) begin errors++; $display("FAIL parity_frame00 got=%b exp=%b", f0, exp_frame(8'h00, 1'b0)); end
      checks++; if (f0[9] !== 1'b1) begin errors++; $display("FAIL parity_bit00 got=%b exp=1", f0[9]); end
      checks++; if (f1 !== exp_frame(8'hFF, 1'b0)) begin errors++; $display("FAIL parity_frameff got=%b exp=%b", f1, exp_frame(8'hFF, 1'b0)); end
      checks++; if (f1[9] !== 1'b1) begin errors++; $display("FAIL parity_bitff got=%b exp=1", f1[9]); end
      checks++; if (rx_t_q[rx_rd + 1] - rx_t_q[rx_rd] != PERIOD) begin
        errors++; $display("FAIL parity_period got=%0d exp=%0d", rx_t_q[rx_rd + 1] - rx_t_q[rx_rd], PERIOD);
      end
      rx_rd += 2;
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    localparam int N = DEPTH + 3;
    logic [7:0] b [N];
    int idx, base, first;
    bit saw_full, rdy;
    base = int'($urandom_range(0, 255));
    for (int i = 0; i < N; i++) b[i] = 8'((base + i * 37) % 256);
    first = rx_rd;
    idx = 0; saw_full = 1'b0;
    for (int k = 0; k < 4000 && idx < N; k++) begin
      @(negedge clk);
      tx_data = b[idx]; tx_valid = 1'b1;
      rdy = tx_ready;
      checks++; if (rdy !== (fifo_count < 4'(DEPTH))) begin errors++; $display("FAIL bp_ready got=%b count=%0d", rdy, fifo_count); end
      if (fifo_count == 4'(DEPTH) && !rdy) saw_full = 1'b1;
      @(posedge clk);
      if (rdy) idx++;
    end
    #1 tx_valid = 1'b0;
    checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL bp_full_seen got=%b exp=1", saw_full); end
    for (int k = 0; k < 3500 && rx_q.size() < first + N; k++) @(negedge clk);
    checks++;
    if (rx_q.size() < first + N) begin
      errors++; $display("FAIL bp_timeout got=%0d frames exp=%0d", rx_q.size() - first, N);
    end else begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (rx_q[first + i] !== exp_frame(b[i], 1'b0)) begin
          errors++; $display("FAIL bp_order idx=%0d got=%b exp=%b", i, rx_q[first + i], exp_frame(b[i], 1'b0));
        end
      end
      rx_rd = first + N;
    end
    wait_idle();
    checks++; if (rx_q.size() != rx_rd) begin errors++; $display("FAIL bp_extra got=%0d exp=%0d", rx_q.size(), rx_rd); end
  endtask

  task automatic test_reset_mid();
    int unsigned t, fc;
    push(8'hA5, t);
    for (int k = 0; k < 600 && !(in_frame && nbit >= 5); k++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++; if (ps2_clk !== 1'b0) begin errors++; $display("FAIL mid_in_low got=%b exp=0", ps2_clk); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (ps2_clk !== 1'b1) begin errors++; $display("FAIL mid_clk got=%b exp=1", ps2_clk); end
    checks++; if (ps2_data !== 1'b1) begin errors++; $display("FAIL mid_data got=%b exp=1", ps2_data); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", fifo_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
    @(negedge clk) rst = 1'b0;
    fc = fall_cnt;
    repeat (300) @(negedge clk);
    checks++; if (fall_cnt != fc) begin errors++; $display("FAIL mid_no_falls got=%0d exp=%0d", fall_cnt - fc, 0); end
    checks++; if (rx_q.size() != rx_rd) begin errors++; $display("FAIL mid_no_frame got=%0d exp=%0d", rx_q.size(), rx_rd); end
    push(8'h5A, t);
    for (int k = 0; k < 600 && rx_q.size() < rx_rd + 1; k++) @(negedge clk);
    checks++;
    if (rx_q.size() < rx_rd + 1) begin
      errors++; $display("FAIL mid_recover_timeout got=%0d exp=1", rx_q.size() - rx_rd);
    end else begin
      checks++; if (rx_q[rx_rd] !== exp_frame(8'h5A, 1'b0)) begin errors++; $display("FAIL mid_recover got=%b exp=%b", rx_q[rx_rd], exp_frame(8'h5A, 1'b0)); end
      rx_rd++;
    end
    wait_idle();
  endtask

`ifdef PS2_KBD_TX_ERRINJ_EN
  task automatic test_errinj();
    logic [10:0] f0, f1;
    push_err(8'h1C, 1'b1);
    push_err(8'h1C, 1'b0);
    for (int k = 0; k < 900 && rx_q.size() < rx_rd + 2; k++) @(negedge clk);
    checks++;
    if (rx_q.size() < rx_rd + 2) begin
      errors++; $display("FAIL err_timeout got=%0d exp=2", rx_q.size() - rx_rd);
    end else begin
      f0 = rx_q[rx_rd]; f1 = rx_q[rx_rd + 1];
      checks++; if (f0 !== exp_frame(8'h1C, 1'b1)) begin errors++; $display("FAIL err_frame got=%b exp=%b", f0, exp_frame(8'h1C, 1'b1)); end
      checks++; if (f0[9] !== 1'b1) begin errors++; $display("FAIL err_parity got=%b exp=1", f0[9]); end
      checks++; if ((^f0[9:1]) !== 1'b0) begin errors++; $display("FAIL err_rx_flag got=%b exp=0", ^f0[9:1]); end
      checks++; if (f1 !== exp_frame(8'h1C, 1'b0)) begin errors++; $display("FAIL err_clean got=%b exp=%b", f1, exp_frame(8'h1C, 1'b0)); end
      checks++; if ((^f1[9:1]) !== 1'b1) begin errors++; $display("FAIL err_clean_rx got=%b exp=1", ^f1[9:1]); end
      rx_rd += 2;
    end
    wait_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_reset_mid();
`ifdef PS2_KBD_TX_ERRINJ_EN
    test_errinj();
`endif
    checks++; if (stab_err != 0) begin errors++; $display("FAIL data_stable_low got=%0d exp=0", stab_err); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
